// File: rtl/input_sync_debounce.sv
// Multi-channel input synchroniser + debouncer with edge pulses and sticky event flags.
// Define INPUT_SYNC_SIM_BYPASS_EN to replace sync/debounce with a combinational pass-through.
module input_sync_debounce #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] evt_pending,
   input  logic [WIDTH-1:0] evt_clr
);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("input_sync_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;
   logic [WIDTH-1:0] evt_d;

`ifdef INPUT_SYNC_SIM_BYPASS_EN

   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= in;
      end
   end

   always_comb begin
      rise_d = in & ~prev_q;
      fall_d = ~in & prev_q;
   end

   assign level_out = in;
   assign rise      = rise_d;
   assign fall      = fall_d;

`else

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] level_d;

   // Count only while the synchronised value disagrees; any agreeing cycle restarts.
   always_comb begin
      sync    = sync_q[SYNC_STAGES-1];
      level_d = level_out;
      for (int c = 0; c < int'(WIDTH); c++) begin
         cnt_d[c] = '0;
         if (sync[c] != level_out[c]) begin
            if (cnt_q[c] == CntLast) begin
               level_d[c] = sync[c];
            end else begin
               cnt_d[c] = cnt_q[c] + 1'b1;
            end
         end
      end
      rise_d = level_d & ~level_out;
      fall_d = ~level_d & level_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= '0;
         end
         for (int c = 0; c < int'(WIDTH); c++) begin
            cnt_q[c] <= '0;
         end
         level_out <= '0;
         rise      <= '0;
         fall      <= '0;
      end else begin
         sync_q[0] <= in;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         for (int c = 0; c < int'(WIDTH); c++) begin
            cnt_q[c] <= cnt_d[c];
         end
         level_out <= level_d;
         rise      <= rise_d;
         fall      <= fall_d;
      end
   end

`endif

   // A new edge outranks a simultaneous clear request.
   always_comb begin
      evt_d = (evt_pending & ~evt_clr) | rise_d | fall_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         evt_pending <= '0;
      end else begin
         evt_pending <= evt_d;
      end
   end

endmodule

// File: doc/input_sync_debounce.md
Name: input_sync_debounce

Overview:
- Parametrised successor to the single-bit two-flop input synchroniser.
- Synchronises WIDTH asynchronous board inputs (buttons, switches, GPIO) into the clk domain through a SYNC_STAGES-deep flop chain.
- Debounces each channel, emits one-cycle rise/fall pulses, and keeps sticky per-channel event flags that downstream logic clears.
- Sits at the top level between the pins and all consumers of external inputs.

Parameters:
- WIDTH, 4: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range 2 to 4.
- DEBOUNCE_CYCLES, 16: consecutive clk cycles a synchronised value must differ from the current level before the level changes; minimum 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in  in  WIDTH  asynchronous raw inputs.
- level_out  out  WIDTH  debounced level.
- rise  out  WIDTH  one-cycle pulse on a debounced 0->1 change.
- fall  out  WIDTH  one-cycle pulse on a debounced 1->0 change.
- evt_pending  out  WIDTH  sticky flag, set by rise or fall.
- evt_clr  in  WIDTH  one-cycle-or-longer clear request for evt_pending.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset:
  - Applies on any posedge clk with reset=1, including mid-debounce.
  - Clears every sync flop, every debounce counter, level_out, rise, fall and evt_pending to 0.
  - All outputs read 0 in the cycle after the reset edge.
  - in is ignored while reset=1.
- Synchroniser:
  - Per channel, s[0] <= in, then s[i] <= s[i-1].
  - sync = s[SYNC_STAGES-1].
  - No logic between stages.
- Debounce, per channel, independent:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync == level_out: the counter clears to 0.
  - If sync != level_out and counter == DEBOUNCE_CYCLES-1: level_out <= sync and the counter clears.
  - Otherwise the counter increments.
  - Any single cycle of sync == level_out restarts the count. A glitch shorter than DEBOUNCE_CYCLES never changes level_out.
  - Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Latency: an input stable from edge k appears on level_out after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (edge 0 samples into s[0]).
- Edge pulses:
  - rise/fall are registered and assert in the same cycle that level_out first shows the new value.
  - They last exactly one cycle.
  - rise and fall are never both high on one channel.
- Event flags:
  - evt_pending[i] <= (evt_pending[i] & ~evt_clr[i]) | rise[i] | fall[i], evaluated with the new pulses as they are registered.
  - Set and clear in the same cycle: set wins.
  - evt_clr held high keeps the flag clear, except in cycles where a new edge occurs.
  - Clearing one channel never affects another.
- Parameter checks: elaboration fails if SYNC_STAGES<2 or DEBOUNCE_CYCLES<1.

Optional Feature:
- Macro: INPUT_SYNC_SIM_BYPASS_EN.
- When defined:
  - Sync chain and debounce counters are not instantiated.
  - level_out = in, combinationally.
  - A single register prev <= in (reset 0) drives rise = in & ~prev and fall = ~in & prev, both combinational.
  - evt_pending logic is unchanged, fed from these pulses.
  - Intended for fast simulation only.
- When undefined: full behaviour above. This is the synthesis default.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset: drive in=4'hF and reset=1 for 3 cycles, then reset=0 -> all outputs 0 during reset. level_out[all]=1 after edge 5 post-release, rise=4'hF for exactly that one cycle.
- Latency: in[0] 0->1 before edge k -> level_out[0]=1 and rise[0]=1 after edge k+5. rise[0]=0 one cycle later. evt_pending[0]=1 and stays 1.
- Glitch rejection: in[1] pulsed high for 3 cycles, then low -> level_out[1], rise[1] and evt_pending[1] stay 0. A 4-cycle pulse produces rise[1] then fall[1].
- Clear vs set collision: evt_pending[2]=1, and evt_clr[2]=1 in the same cycle fall[2] asserts -> evt_pending[2] remains 1. A later lone evt_clr[2] -> 0 next cycle. Other channels are unaffected.
- Reset mid-debounce: in[3] rises, reset=1 asserted after 2 counted cycles -> counter and outputs 0. After release with in[3] still 1, level_out[3]=1 after edge 5.
- Bypass build (INPUT_SYNC_SIM_BYPASS_EN): in[0] 0->1 -> level_out[0]=1 and rise[0]=1 in the same cycle. rise[0] drops after the next edge.
